fifo_ctrl: RTL and testbench

Pointer and flag controller for the single-clock 16-entry FIFO.
- Accepts write/read requests, qualifies them against full/empty, and drives the FIFO RAM write enable, write address, read enable and read address.
- Tracks occupancy and generates registered full, empty and almost-full flags, a read-data-valid strobe, and sticky overflow/underflow error bits.
- Sits between the producer/consumer interfaces and the dual-port FIFO storage array.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_ptr.sv | 34 +++
 rtl/fifo_ctrl.sv | 126 ++++++++++++
 tb/tb_fifo_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing, typedefs and default flag thresholds for the
// 16-entry single-clock FIFO controller.
//   FIFO_ADDR_W    : RAM address width
//   FIFO_DEPTH     : number of storage entries (2**FIFO_ADDR_W)
//   ptr_t          : pointer with extra wrap bit
//   addr_t         : RAM address (pointer low bits)
//   count_t        : occupancy 0..FIFO_DEPTH
//   FIFO_AF_THRESH : default almost_full threshold
//   FIFO_AE_THRESH : default almost_empty threshold (FIFO_ALMOST_EMPTY_EN)
package fifo_pkg;

  localparam int FIFO_ADDR_W    = 4;
  localparam int FIFO_DEPTH     = 1 << FIFO_ADDR_W;
  localparam int FIFO_AF_THRESH = 10;
  localparam int FIFO_AE_THRESH = 2;

  typedef logic [FIFO_ADDR_W:0]   ptr_t;
  typedef logic [FIFO_ADDR_W-1:0] addr_t;
  typedef logic [FIFO_ADDR_W:0]   count_t;

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: FIFO pointer counter with a wrap bit above the address bits.
// The pointer wraps modulo 2*DEPTH so that full and empty are
// distinguishable when the address bits of two pointers match.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, clears the pointer
//   inc  : advance the pointer by one on this edge
//   ptr  : full pointer including wrap bit
//   addr : RAM address slice (pointer without wrap bit)
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  output logic [ADDR_W:0]   ptr,
  output logic [ADDR_W-1:0] addr
);

  // Pointer register: reset wins, otherwise step by one when enabled.
  // Natural overflow of the ADDR_W+1 bit register gives the 2*DEPTH wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + (ADDR_W+1)'(1);
    end
  end

  assign addr = ptr[ADDR_W-1:0];

endmodule

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a single-clock FIFO.
// Qualifies producer/consumer requests against full/empty, drives the
// dual-port RAM strobes and addresses, and keeps registered occupancy,
// status flags, a read-data-valid strobe and sticky error bits.
// Optional feature macro: FIFO_ALMOST_EMPTY_EN adds the almost_empty flag.
// Ports:
//   clk, rst       : clock and synchronous active-high reset
//   wr_en, rd_en   : write / read requests
//   ram_we         : RAM write enable (accepted write, combinational)
//   ram_waddr      : RAM write address
//   ram_re         : RAM read enable (accepted read, combinational)
//   ram_raddr      : RAM read address
//   rd_valid       : RAM read data valid (one cycle after ram_re)
//   count          : occupancy 0..DEPTH
//   full, empty    : count == DEPTH / count == 0
//   almost_full    : count >= AF_THRESH
//   overflow       : sticky, write requested while full
//   underflow      : sticky, read requested while empty
//   almost_empty   : count <= AE_THRESH (FIFO_ALMOST_EMPTY_EN only)
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AF_THRESH = FIFO_AF_THRESH
`ifdef FIFO_ALMOST_EMPTY_EN
  , parameter int AE_THRESH = FIFO_AE_THRESH
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic              ram_re,
  output logic [ADDR_W-1:0] ram_raddr,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              overflow,
  output logic              underflow
`ifdef FIFO_ALMOST_EMPTY_EN
  , output logic            almost_empty
`endif
);

  localparam int DEPTH = 1 << ADDR_W;

  logic              wr_acc;
  logic              rd_acc;
  logic [ADDR_W:0]   wptr;
  logic [ADDR_W:0]   rptr;
  logic [ADDR_W:0]   wptr_next;
  logic [ADDR_W:0]   rptr_next;
  logic [ADDR_W:0]   count_next;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;

  // Request qualification. Reset masks both strobes so nothing reaches
  // the RAM in a reset cycle, and it also freezes the pointers.
  assign wr_acc = wr_en & ~full & ~rst;
  assign rd_acc = rd_en & ~empty & ~rst;

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (wr_acc),
    .ptr  (wptr),
    .addr (waddr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
    .clk  (clk),
    .rst  (rst),
    .inc  (rd_acc),
    .ptr  (rptr),
    .addr (raddr)
  );

  assign ram_we    = wr_acc;
  assign ram_re    = rd_acc;
  assign ram_waddr = waddr;
  assign ram_raddr = raddr;

  // Next occupancy from the post-edge wrap-bit pointers; the modulo
  // 2*DEPTH subtraction keeps full (DEPTH) distinct from empty (0).
  assign wptr_next  = wptr + (ADDR_W+1)'(wr_acc);
  assign rptr_next  = rptr + (ADDR_W+1)'(rd_acc);
  assign count_next = wptr_next - rptr_next;

  // Count, flags and read-valid register from next-state values so they
  // line up with the pointers written on the same edge. Error bits are
  // sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      rd_valid     <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
`ifdef FIFO_ALMOST_EMPTY_EN
      almost_empty <= 1'b1;
`endif
    end else begin
      count        <= count_next;
      full         <= (count_next == (ADDR_W+1)'(DEPTH));
      empty        <= (count_next == '0);
      almost_full  <= (count_next >= (ADDR_W+1)'(AF_THRESH));
      rd_valid     <= rd_acc;
`ifdef FIFO_ALMOST_EMPTY_EN
      almost_empty <= (count_next <= (ADDR_W+1)'(AE_THRESH));
`endif
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed testbench for fifo_ctrl. A behavioural occupancy
// model predicts strobes and flags every cycle; a queue of write addresses
// checks that reads are issued in FIFO order.
// Build with +define+FIFO_ALMOST_EMPTY_EN to also cover almost_empty.
module tb_fifo_ctrl;
  import fifo_pkg::*;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       rd_en;
  logic       ram_we;
  addr_t      ram_waddr;
  logic       ram_re;
  addr_t      ram_raddr;
  logic       rd_valid;
  count_t     count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       overflow;
  logic       underflow;
`ifdef FIFO_ALMOST_EMPTY_EN
  logic       almost_empty;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  int   m_count;
  int   m_wptr;
  int   m_rptr;
  logic m_ovf;
  logic m_unf;
  logic m_rv;
  addr_t sb_q[$];

  fifo_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_re       (ram_re),
    .ram_raddr    (ram_raddr),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .overflow     (overflow),
    .underflow    (underflow)
`ifdef FIFO_ALMOST_EMPTY_EN
    , .almost_empty (almost_empty)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and on mismatch counts and reports the failure.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Registered outputs against the model, sampled 1 time unit after the edge.
  task automatic checkRegs(input string tag);
    checkOutput({tag, " count"}, int'(count), m_count);
    checkOutput({tag, " full"}, int'(full), int'(m_count == FIFO_DEPTH));
    checkOutput({tag, " empty"}, int'(empty), int'(m_count == 0));
    checkOutput({tag, " almost_full"}, int'(almost_full), int'(m_count >= FIFO_AF_THRESH));
    checkOutput({tag, " overflow"}, int'(overflow), int'(m_ovf));
    checkOutput({tag, " underflow"}, int'(underflow), int'(m_unf));
    checkOutput({tag, " rd_valid"}, int'(rd_valid), int'(m_rv));
`ifdef FIFO_ALMOST_EMPTY_EN
    checkOutput({tag, " almost_empty"}, int'(almost_empty), int'(m_count <= FIFO_AE_THRESH));
`endif
  endtask

  // One clock cycle: drive at the falling edge, check the combinational RAM
  // strobes, advance the model over the rising edge, then check registers.
  task automatic applyStimulus(input string tag, input logic w, input logic r, input logic rs);
    logic exp_we;
    logic exp_re;
    addr_t exp_addr;
    @(negedge clk);
    wr_en = w;
    rd_en = r;
    rst   = rs;
    #1;
    exp_we = w && (m_count != FIFO_DEPTH) && !rs;
    exp_re = r && (m_count != 0) && !rs;
    checkOutput({tag, " ram_we"}, int'(ram_we), int'(exp_we));
    checkOutput({tag, " ram_re"}, int'(ram_re), int'(exp_re));
    if (exp_we) begin
      checkOutput({tag, " ram_waddr"}, int'(ram_waddr), m_wptr % FIFO_DEPTH);
      sb_q.push_back(addr_t'(m_wptr % FIFO_DEPTH));
    end
    if (exp_re) begin
      if (sb_q.size() == 0) begin
        checkOutput({tag, " scoreboard_empty"}, 1, 0);
      end else begin
        exp_addr = sb_q.pop_front();
        checkOutput({tag, " ram_raddr"}, int'(ram_raddr), int'(exp_addr));
      end
    end
    @(posedge clk);
    if (rs) begin
      m_count = 0; m_wptr = 0; m_rptr = 0;
      m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0;
      sb_q.delete();
    end else begin
      if (w && m_count == FIFO_DEPTH) m_ovf = 1'b1;
      if (r && m_count == 0) m_unf = 1'b1;
      if (exp_we) m_wptr = (m_wptr + 1) % (2 * FIFO_DEPTH);
      if (exp_re) m_rptr = (m_rptr + 1) % (2 * FIFO_DEPTH);
      m_count = m_count + int'(exp_we) - int'(exp_re);
      m_rv = exp_re;
    end
    #1;
    checkRegs(tag);
  endtask

  initial begin
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b1;
    m_count = 0; m_wptr = 0; m_rptr = 0;
    m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0;

    // Reset for two cycles (requests held high to see strobes masked), then idle
    applyStimulus("reset0", 1'b0, 1'b0, 1'b1);
    applyStimulus("reset1", 1'b1, 1'b1, 1'b1);
    applyStimulus("idle", 1'b0, 1'b0, 1'b0);

    // Fill from empty, then one write while full
    for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus("fill", 1'b1, 1'b0, 1'b0);
    checkOutput("fill full", int'(full), 1);
    applyStimulus("overwrite", 1'b1, 1'b0, 1'b0);

    // Drain from full, then one read while empty
    for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus("drain", 1'b0, 1'b1, 1'b0);
    applyStimulus("overread", 1'b0, 1'b1, 1'b0);
    checkOutput("overread underflow", int'(underflow), 1);

    // Simultaneous read/write at count 5 long enough to wrap both pointers
    applyStimulus("rst_sim", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus("pre_sim", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) applyStimulus("sim", 1'b1, 1'b1, 1'b0);
    checkOutput("sim count", int'(count), 5);

    // Full boundary: write dropped, read accepted
    applyStimulus("rst_fb", 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < FIFO_DEPTH; i++) applyStimulus("fill_fb", 1'b1, 1'b0, 1'b0);
    applyStimulus("full_wr_rd", 1'b1, 1'b1, 1'b0);
    checkOutput("full_wr_rd count", int'(count), 15);

    // Empty boundary: read dropped, write accepted
    for (int i = 0; i < FIFO_DEPTH - 1; i++) applyStimulus("drain_eb", 1'b0, 1'b1, 1'b0);
    applyStimulus("empty_wr_rd", 1'b1, 1'b1, 1'b0);
    checkOutput("empty_wr_rd count", int'(count), 1);

    // Reset mid-operation at count 9 with a write pending
    for (int i = 0; i < 8; i++) applyStimulus("to9", 1'b1, 1'b0, 1'b0);
    checkOutput("to9 count", int'(count), 9);
    applyStimulus("mid_reset", 1'b1, 1'b0, 1'b1);
    applyStimulus("post_reset", 1'b0, 1'b0, 1'b0);

    // Almost-empty boundary walk (checked per cycle when the flag exists)
    for (int i = 0; i < 3; i++) applyStimulus("ae_walk", 1'b1, 1'b0, 1'b0);
    applyStimulus("ae_back", 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
